hls_deadlock_monitor_n: RTL

//  Parametrised deadlock monitor for HLS dataflow regions. Watches N_AXIS stream

---
 rtl/hls_deadlock_monitor_n.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hls_deadlock_monitor_n.sv
// hls_deadlock_monitor_n -- deadlock monitor for one HLS dataflow region.
//
// Watches per-stream block flags and per-instance block/idle pairs. Reports
// a registered raw block flag every cycle, plus a sticky deadlock flag that
// trips once the region has been blocked for `threshold` consecutive cycles
// while armed. At the trip edge the culprit index and the full block vector
// are captured and held until clear or reset.
//
// Optional feature: define DEADLOCK_MON_TRACE_EN to add a free-running cycle
// counter and the trip_ts port (counter value captured at the trip edge).
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   axis_block_sigs     [N_AXIS]  per-stream block flags
//   inst_idle_sigs      [N_INST]  per-instance idle flags
//   inst_block_sigs     [N_INST]  per-instance block flags
//   enable              arm detection
//   clear               drop sticky state, restart detection
//   threshold           consecutive blocked cycles to trip (0 acts as 1)
//   block               raw block, one cycle late
//   deadlock            sticky trip flag
//   first_idx           lowest blocked index at trip (inst i -> N_AXIS+i)
//   blocked_mask        block vector snapshot at trip
//   stall_cnt           consecutive blocked cycles, saturating
//   trip_ts             cycle stamp of trip (DEADLOCK_MON_TRACE_EN only)

// Per-instance lane: an idle instance is never considered blocked.
module hls_dlm_inst_lane (
  input  logic inst_block,
  input  logic inst_idle,
  output logic blocked
);
  assign blocked = inst_block & ~inst_idle;
endmodule

module hls_deadlock_monitor_n #(
  parameter int N_AXIS   = 3,
  parameter int N_INST   = 2,
  parameter int THRESH_W = 16,
  parameter int TS_W     = 32,
  localparam int N_VEC   = N_AXIS + N_INST,
  localparam int IDX_W   = (N_VEC <= 1) ? 1 : $clog2(N_VEC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_AXIS-1:0]   axis_block_sigs,
  input  logic [N_INST-1:0]   inst_idle_sigs,
  input  logic [N_INST-1:0]   inst_block_sigs,
  input  logic                enable,
  input  logic                clear,
  input  logic [THRESH_W-1:0] threshold,
  output logic                block,
  output logic                deadlock,
  output logic [IDX_W-1:0]    first_idx,
  output logic [N_VEC-1:0]    blocked_mask,
  output logic [THRESH_W-1:0] stall_cnt
`ifdef DEADLOCK_MON_TRACE_EN
  ,
  output logic [TS_W-1:0]     trip_ts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_TRIPPED} state_t;

  localparam logic [THRESH_W-1:0] CNT_ONE = 1;
  localparam logic [THRESH_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic [N_INST-1:0]   inst_eff;
  logic [N_VEC-1:0]    vec;
  logic                raw;
  logic [THRESH_W-1:0] thr_eff;
  logic [THRESH_W-1:0] cnt_inc;
  logic [IDX_W-1:0]    low_idx;
  logic                trip_now;

  for (genvar i = 0; i < N_INST; i++) begin : g_lane
    hls_dlm_inst_lane u_lane (
      .inst_block (inst_block_sigs[i]),
      .inst_idle  (inst_idle_sigs[i]),
      .blocked    (inst_eff[i])
    );
  end

  assign vec     = {inst_eff, axis_block_sigs};
  assign raw     = |vec;
  assign thr_eff = (threshold == '0) ? CNT_ONE : threshold;
  // Cannot overflow in COUNT: stall_cnt < thr_eff <= all-ones there.
  assign cnt_inc = stall_cnt + CNT_ONE;

  // Lowest set bit; scanning downward lets the lowest index win.
  always_comb begin
    low_idx = '0;
    for (int i = N_VEC - 1; i >= 0; i--)
      if (vec[i]) low_idx = IDX_W'(i);
  end

  always_comb begin
    trip_now = 1'b0;
    if (!clear && enable && raw) begin
      if (state == S_IDLE)  trip_now = (thr_eff == CNT_ONE);
      if (state == S_COUNT) trip_now = (cnt_inc >= thr_eff);
    end
  end

`ifdef DEADLOCK_MON_TRACE_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running stamp; not affected by clear.
  always_ff @(posedge clock) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) trip_ts <= '0;
    else if (trip_now)  trip_ts <= ts_cnt;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      block        <= 1'b0;
      deadlock     <= 1'b0;
      first_idx    <= '0;
      blocked_mask <= '0;
      stall_cnt    <= '0;
    end else begin
      block <= raw;
      if (clear) begin
        // raw on the clear cycle is deliberately not counted.
        state        <= S_IDLE;
        deadlock     <= 1'b0;
        first_idx    <= '0;
        blocked_mask <= '0;
        stall_cnt    <= '0;
      end else begin
        if (trip_now) begin
          deadlock     <= 1'b1;
          blocked_mask <= vec;
          first_idx    <= low_idx;
        end
        case (state)
          S_IDLE: begin
            if (enable && raw) begin
              stall_cnt <= CNT_ONE;
              state     <= trip_now ? S_TRIPPED : S_COUNT;
            end else begin
              stall_cnt <= '0;
            end
          end
          S_COUNT: begin
            if (!raw || !enable) begin
              stall_cnt <= '0;
              state     <= S_IDLE;
            end else begin
              stall_cnt <= cnt_inc;
              if (trip_now) state <= S_TRIPPED;
            end
          end
          S_TRIPPED: begin
            // Sticky until clear; enable is ignored here.
            if (!raw)                  stall_cnt <= '0;
            else if (stall_cnt != CNT_MAX) stall_cnt <= cnt_inc;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
